// File: rtl/avalon_gpio_irq.sv
// Avalon-MM parallel-port slave: debounced inputs with edge capture, atomic set/clear outputs,
// and one maskable level interrupt. Fixed read latency of one cycle, never stalls.
module avalon_gpio_irq #(
    parameter int unsigned      WIDTH           = 18,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic [3:0]       avs_byteenable,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    output logic             avs_waitrequest,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd6;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd7;

    // Input path state
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Software-visible registers
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;

    // Bus response and interrupt
    logic [31:0] readdata_q, readdata_d;
    logic        readdatavalid_q;
    logic        irq_q, irq_d;

    logic [31:0]      be_mask;
    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [31:0]      rd_mux;
    logic             unused_bus_bits;

    // Expand byte enables to a per-bit write mask
    always_comb begin
        be_mask = '0;
        for (int b = 0; b < 4; b++) begin
            be_mask[8*b +: 8] = {8{avs_byteenable[b]}};
        end
    end

    assign wr_mask = be_mask[WIDTH-1:0];
    assign wr_bits = avs_writedata[WIDTH-1:0] & wr_mask;

    // Lanes above WIDTH have no storage behind them
    assign unused_bus_bits = ^{avs_writedata, be_mask};

    // ------------------------------------------------------------------
    // Synchroniser and debouncer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= in_port;
            s2_q <= s1_q;
        end
    end

    // Counter restarts whenever s2 agrees with the accepted level, so glitches leave no trace.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise     = stable_q & ~stable_dly_q;
    assign fall     = ~stable_q & stable_dly_q;
    assign edge_hit = (rise & rise_en_q) | (fall & fall_en_q);

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_comb begin
        data_out_d = data_out_q;
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        cap_clr    = '0;
        if (avs_write) begin
            case (avs_address)
                ADDR_DATA_OUT: data_out_d = (data_out_q & ~wr_mask) | wr_bits;
                ADDR_IRQ_MASK: irq_mask_d = (irq_mask_q & ~wr_mask) | wr_bits;
                ADDR_EDGE_CAP: cap_clr    = wr_bits;
                ADDR_RISE_EN:  rise_en_d  = (rise_en_q & ~wr_mask) | wr_bits;
                ADDR_FALL_EN:  fall_en_d  = (fall_en_q & ~wr_mask) | wr_bits;
                ADDR_OUT_SET:  data_out_d = data_out_q | wr_bits;
                ADDR_OUT_CLR:  data_out_d = data_out_q & ~wr_bits;
                default:       ;
            endcase
        end
    end

    // A new edge overrides a simultaneous clear of the same bit.
    assign edge_cap_d = (edge_cap_q & ~cap_clr) | edge_hit;
    assign irq_d      = |(edge_cap_q & irq_mask_q);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            data_out_q <= OUT_RESET;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_q      <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path: sampled from pre-write register values
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_DATA_IN:  rd_mux = 32'(stable_q);
            ADDR_DATA_OUT: rd_mux = 32'(data_out_q);
            ADDR_IRQ_MASK: rd_mux = 32'(irq_mask_q);
            ADDR_EDGE_CAP: rd_mux = 32'(edge_cap_q);
            ADDR_RISE_EN:  rd_mux = 32'(rise_en_q);
            ADDR_FALL_EN:  rd_mux = 32'(fall_en_q);
            default:       rd_mux = '0;
        endcase
    end

    assign readdata_d = avs_read ? rd_mux : readdata_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= avs_read;
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;
    assign avs_waitrequest   = 1'b0;
    assign out_port          = data_out_q;
    assign irq               = irq_q;

endmodule
